// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller: latched floor calls, SCAN (collective) scheduling,
// prescaled travel and door-dwell timing, and a level-sensitive emergency stop.
module elevator_scan_ctrl #(
   parameter int unsigned N_FLOORS     = 4,
   parameter int unsigned TICK_DIV     = 50000000,
   parameter int unsigned TRAVEL_TICKS = 2,
   parameter int unsigned DOOR_TICKS   = 3,
   localparam int unsigned FW          = $clog2(N_FLOORS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] call_req,
   input  logic                emergency_stop,
   output logic [FW-1:0]       cur_floor,
   output logic [N_FLOORS-1:0] floor_onehot,
   output logic [N_FLOORS-1:0] pending,
   output logic                moving,
   output logic                door_open,
   output logic                up_led,
   output logic                down_led,
   output logic                estop_active
);

   localparam int unsigned PW  = $clog2(TICK_DIV);
   localparam int unsigned TCW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
   localparam int unsigned DCW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MOVING = 2'd1,
      S_DOOR   = 2'd2,
      S_ESTOP  = 2'd3
   } state_t;

   state_t              state;
   logic [PW-1:0]       pcnt;
   logic [TCW-1:0]      tcnt;
   logic [DCW-1:0]      dcnt;
   logic                dir;

   logic                tick;
   logic [N_FLOORS-1:0] pend_in;
   logic [FW-1:0]       nf;
   logic                above;
   logic                below;
   logic                nf_above;
   logic                nf_below;

   function automatic logic [N_FLOORS-1:0] onehot(input logic [FW-1:0] f);
      return N_FLOORS'(1) << f;
   endfunction

   // Prescaler tick, request merge, and the floor the car reaches next (clamped at the ends).
   always_comb begin
      tick    = (pcnt == PW'(TICK_DIV - 1));
      pend_in = pending | call_req;
      nf      = cur_floor;
      if (dir && (cur_floor != FW'(N_FLOORS - 1))) begin
         nf = cur_floor + FW'(1);
      end else if (!dir && (cur_floor != '0)) begin
         nf = cur_floor - FW'(1);
      end
   end

   // Outstanding requests relative to the current floor and to the floor being reached.
   always_comb begin
      above    = 1'b0;
      below    = 1'b0;
      nf_above = 1'b0;
      nf_below = 1'b0;
      for (int unsigned i = 0; i < N_FLOORS; i++) begin
         if (pending[i]) begin
            if (FW'(i) > cur_floor) above    = 1'b1;
            if (FW'(i) < cur_floor) below    = 1'b1;
            if (FW'(i) > nf)        nf_above = 1'b1;
            if (FW'(i) < nf)        nf_below = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         pcnt         <= '0;
         tcnt         <= '0;
         dcnt         <= '0;
         dir          <= 1'b1;
         cur_floor    <= '0;
         floor_onehot <= N_FLOORS'(1);
         pending      <= '0;
         moving       <= 1'b0;
         door_open    <= 1'b0;
         up_led       <= 1'b0;
         down_led     <= 1'b0;
         estop_active <= 1'b0;
      end else begin
         pcnt         <= tick ? '0 : pcnt + PW'(1);
         pending      <= pend_in;
         moving       <= 1'b0;
         door_open    <= 1'b0;
         up_led       <= 1'b0;
         down_led     <= 1'b0;
         estop_active <= 1'b0;

         if (emergency_stop) begin
            // Floor, direction and requests hold; partial travel is thrown away.
            state        <= S_ESTOP;
            tcnt         <= '0;
            dcnt         <= '0;
            estop_active <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  tcnt <= '0;
                  dcnt <= '0;
                  if (pending[cur_floor]) begin
                     state     <= S_DOOR;
                     door_open <= 1'b1;
                     pending   <= pend_in & ~onehot(cur_floor);
                  end else if (above && (dir || !below)) begin
                     state  <= S_MOVING;
                     dir    <= 1'b1;
                     moving <= 1'b1;
                     up_led <= 1'b1;
                  end else if (below) begin
                     state    <= S_MOVING;
                     dir      <= 1'b0;
                     moving   <= 1'b1;
                     down_led <= 1'b1;
                  end
               end

               S_MOVING: begin
                  moving   <= 1'b1;
                  up_led   <= dir;
                  down_led <= !dir;
                  if (tick) begin
                     if (tcnt == TCW'(TRAVEL_TICKS - 1)) begin
                        tcnt         <= '0;
                        cur_floor    <= nf;
                        floor_onehot <= onehot(nf);
                        if (pending[nf]) begin
                           state     <= S_DOOR;
                           dcnt      <= '0;
                           pending   <= pend_in & ~onehot(nf);
                           moving    <= 1'b0;
                           up_led    <= 1'b0;
                           down_led  <= 1'b0;
                           door_open <= 1'b1;
                        end else if (!(dir ? nf_above : nf_below)) begin
                           if (dir ? nf_below : nf_above) begin
                              dir      <= !dir;
                              up_led   <= !dir;
                              down_led <= dir;
                           end else begin
                              state    <= S_IDLE;
                              moving   <= 1'b0;
                              up_led   <= 1'b0;
                              down_led <= 1'b0;
                           end
                        end
                        // An end floor can only be left the other way.
                        if (nf == FW'(N_FLOORS - 1)) begin
                           dir <= 1'b0;
                        end else if (nf == '0) begin
                           dir <= 1'b1;
                        end
                     end else begin
                        tcnt <= tcnt + TCW'(1);
                     end
                  end
               end

               S_DOOR: begin
                  door_open <= 1'b1;
                  pending   <= pend_in & ~onehot(cur_floor);
                  if (call_req[cur_floor]) begin
                     dcnt <= '0;
                  end else if (tick) begin
                     if (dcnt == DCW'(DOOR_TICKS - 1)) begin
                        state     <= S_IDLE;
                        door_open <= 1'b0;
                        dcnt      <= '0;
                     end else begin
                        dcnt <= dcnt + DCW'(1);
                     end
                  end
               end

               S_ESTOP: begin
                  state <= S_IDLE;
                  tcnt  <= '0;
                  dcnt  <= '0;
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural elevator model.
module tb_elevator_scan_ctrl;

   localparam int N  = 4;
   localparam int TD = 4;
   localparam int TT = 2;
   localparam int DT = 3;

   localparam int M_IDLE  = 0;
   localparam int M_MOVE  = 1;
   localparam int M_DOOR  = 2;
   localparam int M_ESTOP = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] call_req;
   logic         emergency_stop;
   logic [1:0]   cur_floor;
   logic [N-1:0] floor_onehot;
   logic [N-1:0] pending;
   logic         moving;
   logic         door_open;
   logic         up_led;
   logic         down_led;
   logic         estop_active;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   int           m_mode;
   int           m_floor;
   int           m_trav;
   int           m_door;
   int           m_cyc;
   bit           m_dir;
   logic [N-1:0] m_pend;

   elevator_scan_ctrl #(
      .N_FLOORS    (N),
      .TICK_DIV    (TD),
      .TRAVEL_TICKS(TT),
      .DOOR_TICKS  (DT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .call_req      (call_req),
      .emergency_stop(emergency_stop),
      .cur_floor     (cur_floor),
      .floor_onehot  (floor_onehot),
      .pending       (pending),
      .moving        (moving),
      .door_open     (door_open),
      .up_led        (up_led),
      .down_led      (down_led),
      .estop_active  (estop_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit req_above(input logic [N-1:0] p, input int f);
      for (int i = f + 1; i < N; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit req_below(input logic [N-1:0] p, input int f);
      for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   // One clock of the car's behaviour, decided from the requests latched before this edge.
   task automatic model_step();
      bit           tick;
      logic [N-1:0] old;
      logic [N-1:0] req;
      logic [N-1:0] bitf;
      tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      old = m_pend;
      req = m_pend | call_req;
      if (emergency_stop) begin
         m_mode = M_ESTOP;
         m_trav = 0;
         m_door = 0;
         m_pend = req;
         return;
      end
      m_pend = req;
      case (m_mode)
         M_ESTOP: m_mode = M_IDLE;
         M_IDLE: begin
            if (old[m_floor]) begin
               m_mode = M_DOOR;
               m_door = 0;
               bitf   = 4'(1) << m_floor;
               m_pend = req & ~bitf;
            end else if (req_above(old, m_floor) && (m_dir || !req_below(old, m_floor))) begin
               m_dir  = 1'b1;
               m_mode = M_MOVE;
               m_trav = 0;
            end else if (req_below(old, m_floor)) begin
               m_dir  = 1'b0;
               m_mode = M_MOVE;
               m_trav = 0;
            end
         end
         M_MOVE: begin
            if (tick) m_trav++;
            if (m_trav == TT) begin
               m_trav  = 0;
               m_floor = m_dir ? m_floor + 1 : m_floor - 1;
               if (old[m_floor]) begin
                  m_mode = M_DOOR;
                  m_door = 0;
                  bitf   = 4'(1) << m_floor;
                  m_pend = req & ~bitf;
               end else if (m_dir ? req_above(old, m_floor) : req_below(old, m_floor)) begin
                  m_mode = M_MOVE;
               end else if (m_dir ? req_below(old, m_floor) : req_above(old, m_floor)) begin
                  m_dir = !m_dir;
               end else begin
                  m_mode = M_IDLE;
               end
               if (m_floor == N - 1) m_dir = 1'b0;
               else if (m_floor == 0) m_dir = 1'b1;
            end
         end
         M_DOOR: begin
            bitf   = 4'(1) << m_floor;
            m_pend = req & ~bitf;
            if (call_req[m_floor]) begin
               m_door = 0;
            end else if (tick) begin
               m_door++;
               if (m_door == DT) begin
                  m_mode = M_IDLE;
                  m_door = 0;
               end
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_mode  = M_IDLE;
         m_floor = 0;
         m_dir   = 1'b1;
         m_pend  = '0;
         m_trav  = 0;
         m_door  = 0;
         m_cyc   = 0;
      end else begin
         model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      check("cmp_floor",   32'(cur_floor),    32'(m_floor));
      check("cmp_onehot",  32'(floor_onehot), 32'(1) << m_floor);
      check("cmp_pending", 32'(pending),      32'(m_pend));
      check("cmp_moving",  32'(moving),       32'(m_mode == M_MOVE));
      check("cmp_door",    32'(door_open),    32'(m_mode == M_DOOR));
      check("cmp_up",      32'(up_led),       32'(m_mode == M_MOVE && m_dir));
      check("cmp_down",    32'(down_led),     32'(m_mode == M_MOVE && !m_dir));
      check("cmp_estop",   32'(estop_active), 32'(m_mode == M_ESTOP));
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [N-1:0] v);
      call_req = v;
      step(1);
      call_req = '0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (!(moving === 1'b0 && door_open === 1'b0 && estop_active === 1'b0 &&
               pending === 4'b0000) && n < budget) begin
         step(1);
         n++;
      end
      check(name, 32'(n < budget), 32'(1));
   endtask

   task automatic wait_floor(input string name, input int target, input int budget);
      int n = 0;
      while (int'(cur_floor) != target && n < budget) begin
         step(1);
         n++;
      end
      check(name, 32'(n < budget), 32'(1));
   endtask

   task automatic count_door(output int n);
      n = 0;
      while (door_open === 1'b1 && n < 40) begin
         n++;
         step(1);
      end
   endtask

   initial begin : main
      int t[4];
      int f;
      int b;
      int n;
      bit ok;
      bit prev_door;
      bit saw_down;
      int stops[$];

      rst            = 1'b1;
      call_req       = '0;
      emergency_stop = 1'b0;
      step(3);
      check("rst_floor",  32'(cur_floor),    32'(0));
      check("rst_onehot", 32'(floor_onehot), 32'(1));
      check("rst_status", 32'({pending, moving, door_open, up_led, down_led, estop_active}), 32'(0));
      rst = 1'b0;

      // Idle after reset with no calls
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("s1_floor",  32'(cur_floor),    32'(0));
         check("s1_onehot", 32'(floor_onehot), 32'(1));
         check("s1_status", 32'({pending, moving, door_open, up_led, down_led, estop_active}), 32'(0));
      end

      // Single call to the top floor
      pulse(4'b1000);
      check("s2_latch",   32'(pending), 32'(4'b1000));
      check("s2_latency", 32'(moving),  32'(0));
      step(1);
      check("s2_moving",  32'(moving), 32'(1));
      check("s2_up_led",  32'(up_led), 32'(1));
      t[0] = cyc;
      f    = 0;
      ok   = 1'b1;
      while (f < 3 && ok) begin
         b = 0;
         while (int'(cur_floor) == f && b < 40) begin
            step(1);
            b++;
         end
         if (b >= 40 || int'(cur_floor) != f + 1) ok = 1'b0;
         else begin
            f++;
            t[f] = cyc;
         end
      end
      check("s2_reach_top",   32'(ok), 32'(1));
      check("s2_first_min",   32'((t[1] - t[0]) >= 5), 32'(1));
      check("s2_first_max",   32'((t[1] - t[0]) <= 8), 32'(1));
      check("s2_step_1_2",    32'(t[2] - t[1]), 32'(8));
      check("s2_step_2_3",    32'(t[3] - t[2]), 32'(8));
      check("s2_door_at_top", 32'(door_open), 32'(1));
      check("s2_cleared",     32'(pending),   32'(0));
      check("s2_model_floor", 32'(m_floor),   32'(3));
      check("s2_model_door",  32'(m_mode),    32'(M_DOOR));
      count_door(n);
      check("s2_dwell", 32'(n), 32'(12));
      check("s2_idle",  32'({moving, door_open}), 32'(0));

      // SCAN ordering: pick up 2 on the way up, 3, then reverse to 0
      pulse(4'b0001);
      wait_idle("s3_to_ground", 200);
      check("s3_at_ground", 32'(cur_floor), 32'(0));
      pulse(4'b1000);
      wait_floor("s3_reach_1", 1, 60);
      pulse(4'b0101);
      prev_door = 1'b0;
      saw_down  = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (door_open && !prev_door) stops.push_back(int'(cur_floor));
         prev_door = door_open;
         if (down_led) saw_down = 1'b1;
         if (stops.size() >= 3 && !moving && !door_open && pending == 4'b0000) break;
         step(1);
      end
      check("s3_nstops",  32'(stops.size()), 32'(3));
      check("s3_stop0",   32'(stops.size() > 0 ? stops[0] : -1), 32'(2));
      check("s3_stop1",   32'(stops.size() > 1 ? stops[1] : -1), 32'(3));
      check("s3_stop2",   32'(stops.size() > 2 ? stops[2] : -1), 32'(0));
      check("s3_down",    32'(saw_down), 32'(1));
      check("s3_pending", 32'(pending),  32'(0));

      // Emergency stop between floors 1 and 2
      pulse(4'b1000);
      wait_floor("s4_reach_1", 1, 60);
      step(3);
      emergency_stop = 1'b1;
      step(1);
      check("s4_estop",   32'(estop_active), 32'(1));
      check("s4_halt",    32'({moving, up_led, down_led, door_open}), 32'(0));
      call_req = 4'b0001;
      step(1);
      call_req = '0;
      step(4);
      check("s4_hold_floor",   32'(cur_floor),    32'(1));
      check("s4_hold_estop",   32'(estop_active), 32'(1));
      check("s4_hold_halt",    32'(moving),       32'(0));
      check("s4_latch_in_stop", 32'(pending),     32'(4'b1001));
      emergency_stop = 1'b0;
      step(1);
      check("s4_release",  32'({estop_active, moving}), 32'(0));
      step(1);
      check("s4_resume",   32'(moving), 32'(1));
      check("s4_resume_up", 32'(up_led), 32'(1));
      n = 0;
      while (int'(cur_floor) == 1 && n < 40) begin
         n++;
         step(1);
      end
      check("s4_next_floor",  32'(cur_floor), 32'(2));
      check("s4_travel_min",  32'(n >= 5), 32'(1));
      check("s4_travel_max",  32'(n <= 8), 32'(1));
      wait_idle("s4_finish", 400);

      // Call at the idle floor, then re-press during the dwell
      pulse(4'b0100);
      wait_idle("s5_to_2", 200);
      check("s5_at_2", 32'(cur_floor), 32'(2));
      pulse(4'b0100);
      check("s5_latched",  32'(pending),   32'(4'b0100));
      check("s5_not_open", 32'(door_open), 32'(0));
      step(1);
      check("s5_open",     32'(door_open), 32'(1));
      check("s5_cleared",  32'(pending),   32'(0));
      step(5);
      pulse(4'b0100);
      check("s5_absorbed", 32'(pending),   32'(0));
      check("s5_still_open", 32'(door_open), 32'(1));
      count_door(n);
      check("s5_restart_min", 32'(n >= 9),  32'(1));
      check("s5_restart_max", 32'(n <= 12), 32'(1));

      // Reset while moving with requests outstanding
      pulse(4'b1010);
      check("s6_latched", 32'(pending), 32'(4'b1010));
      step(1);
      check("s6_moving",  32'(moving),  32'(1));
      step(2);
      check("s6_pending", 32'(pending), 32'(4'b1010));
      rst = 1'b1;
      step(1);
      check("s6_floor",  32'(cur_floor),    32'(0));
      check("s6_onehot", 32'(floor_onehot), 32'(1));
      check("s6_status", 32'({pending, moving, door_open, up_led, down_led, estop_active}), 32'(0));
      rst = 1'b0;

      // Random traffic with occasional emergency stops and resets
      for (int c = 0; c < 3000; c++) begin
         call_req = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         if (emergency_stop) begin
            if ($urandom_range(0, 9) == 0) emergency_stop = 1'b0;
         end else if ($urandom_range(0, 199) == 0) begin
            emergency_stop = 1'b1;
         end
         rst = ($urandom_range(0, 1499) == 0);
         step(1);
      end
      rst            = 1'b0;
      call_req       = '0;
      emergency_stop = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
